// File: rtl/stepper_cmd_if.sv
// Move-command channel between the panel/rotary logic and the stepper sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid and cmd_ready
// are both 1. The master holds cmd_steps/cmd_dir/cmd_mode stable while cmd_valid=1.
// The slave drives cmd_ready from a register; it never depends on cmd_valid.
interface stepper_cmd_if #(
  parameter int STEP_CNT_W = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [STEP_CNT_W-1:0] cmd_steps;
  logic                  cmd_dir;
  logic [1:0]            cmd_mode;

  modport master (
    output cmd_valid,
    output cmd_steps,
    output cmd_dir,
    output cmd_mode,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_steps,
    input  cmd_dir,
    input  cmd_mode,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_seq_ctrl.sv
// Stepper sequencer for one dual H-bridge channel: accepts move commands, walks the
// half-step phase index at a fixed period, drives the bridge pins, standby and the
// VREF current-limit PWM. All outputs are registered.
module stepper_seq_ctrl #(
  parameter int STEP_PERIOD = 50000,
  parameter int STEP_CNT_W  = 16,
  parameter int VREF_W      = 4,
  parameter int HOLD_SHIFT  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stepper_cmd_if.slave          cmd,
  input  logic                  abort,
  input  logic                  hold_en,
  input  logic [VREF_W-1:0]     vref_level,
  output logic                  busy,
  output logic                  done,
  output logic [STEP_CNT_W-1:0] steps_left,
  output logic [2:0]            phase_idx,
  output logic                  ina1,
  output logic                  ina2,
  output logic                  inb1,
  output logic                  inb2,
  output logic                  standby,
  output logic                  vref_pwm,
  output logic                  dbg_run
);

  localparam int TMR_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_PERIOD - 1);

  localparam logic [1:0] MODE_WAVE = 2'd0;
  localparam logic [1:0] MODE_FULL = 2'd1;
  localparam logic [1:0] MODE_HALF = 2'd2;
  localparam logic [1:0] MODE_OFF  = 2'd3;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                state, state_d;
  logic                  ready_q, ready_d;
  logic                  busy_d, done_d;
  logic [STEP_CNT_W-1:0] steps_d;
  logic [2:0]            idx_d;
  logic                  dir_q, dir_d;
  logic [1:0]            mode_q, mode_d;
  logic [TMR_W-1:0]      timer, timer_d;
  logic                  run_d, hold_d, standby_d;
  logic [3:0]            pins_d;
  logic [VREF_W-1:0]     cnt, cnt_n, lvl_q, lvl_sel, lvl_d;
  logic                  pwm_d;

  // Stride is 1 for half-step, or when the index parity does not match the
  // latched mode (wave lives on even indices, full on odd), otherwise 2.
  function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic dir,
                                          input logic [1:0] mode);
    logic [2:0] stride;
    stride = 3'd2;
    if (mode == MODE_HALF)                  stride = 3'd1;
    else if (mode == MODE_WAVE && idx[0])   stride = 3'd1;
    else if (mode == MODE_FULL && !idx[0])  stride = 3'd1;
    next_idx = dir ? idx + stride : idx - stride;
  endfunction

  // Coil table as {ina1, ina2, inb1, inb2}; '+' = 10, '-' = 01, '0' = 00.
  function automatic logic [3:0] coil_pins(input logic [2:0] idx);
    case (idx)
      3'd0:    coil_pins = 4'b10_00;
      3'd1:    coil_pins = 4'b10_10;
      3'd2:    coil_pins = 4'b00_10;
      3'd3:    coil_pins = 4'b01_10;
      3'd4:    coil_pins = 4'b01_00;
      3'd5:    coil_pins = 4'b01_01;
      3'd6:    coil_pins = 4'b00_01;
      default: coil_pins = 4'b10_01;
    endcase
  endfunction

  assign cmd.cmd_ready = ready_q;
  assign dbg_run       = (state == S_RUN);

  // Command acceptance, step timing, index walk and move termination.
  always_comb begin
    state_d = state;
    ready_d = ready_q;
    busy_d  = busy;
    done_d  = 1'b0;
    steps_d = steps_left;
    idx_d   = phase_idx;
    dir_d   = dir_q;
    mode_d  = mode_q;
    timer_d = timer;
    case (state)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (cmd.cmd_valid && ready_q) begin
          dir_d   = cmd.cmd_dir;
          mode_d  = cmd.cmd_mode;
          timer_d = '0;
          if (cmd.cmd_steps == '0 || cmd.cmd_mode == MODE_OFF) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            ready_d = 1'b0;
            steps_d = cmd.cmd_steps;
          end
        end
      end
      S_RUN: begin
        // abort takes priority over a step landing on the same edge
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else if (timer == TMR_LAST) begin
          timer_d = '0;
          idx_d   = next_idx(phase_idx, dir_q, mode_q);
          steps_d = steps_left - 1'b1;
          if (steps_left == STEP_CNT_W'(1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bridge energising and VREF level, computed from next-state values so pins,
  // standby and PWM change on the same edge as phase_idx and state.
  always_comb begin
    run_d     = (state_d == S_RUN);
    hold_d    = !run_d && hold_en && (mode_d != MODE_OFF);
    standby_d = run_d || hold_d;
    pins_d    = standby_d ? coil_pins(idx_d) : 4'b0000;
    lvl_sel   = '0;
    if (run_d)       lvl_sel = vref_level;
    else if (hold_d) lvl_sel = vref_level >> HOLD_SHIFT;
    cnt_n = cnt + 1'b1;
    // the level for the period starting at cnt=0 is captured on the wrap edge
    lvl_d = (cnt == '1) ? lvl_sel : lvl_q;
    pwm_d = standby_d && (cnt_n < lvl_d);
  end

  // State and output registers; async reset de-energises the bridge at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ready_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      steps_left <= '0;
      phase_idx  <= 3'd0;
      dir_q      <= 1'b0;
      mode_q     <= MODE_OFF;
      timer      <= '0;
      {ina1, ina2, inb1, inb2} <= 4'b0000;
      standby    <= 1'b0;
      cnt        <= '0;
      lvl_q      <= '0;
      vref_pwm   <= 1'b0;
    end else begin
      state      <= state_d;
      ready_q    <= ready_d;
      busy       <= busy_d;
      done       <= done_d;
      steps_left <= steps_d;
      phase_idx  <= idx_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
      timer      <= timer_d;
      {ina1, ina2, inb1, inb2} <= pins_d;
      standby    <= standby_d;
      cnt        <= cnt_n;
      lvl_q      <= lvl_d;
      vref_pwm   <= pwm_d;
    end
  end

endmodule
